trig_delay_gen: RTL and testbench
=================================

TRIG_DELAY_GEN -- requirements
Module: trig_delay_gen

Interface
REQ-001 Parameter ID_W, default 8: width of the transmit/trigger ID, which is also the Delay_RAM read address.
REQ-002 Parameter DLY_W, default 16: width of the delay word read from Delay_RAM, in I_DELY_CLK cycles.
REQ-003 Port I_DELY_CLK, input, 1: the only clock (250 MHz delay domain); one clock; reset is synchronous and active-low.
REQ-004 Port I_Rst_n, input, 1: synchronous active-low reset.
REQ-005 Port I_ENABLE, input, 1: channel enable; when low, triggers are ignored.
REQ-006 Port I_TRIG, input, 1: single-cycle trigger request.
REQ-007 Port I_TX_ID, input, ID_W: ID qualifying I_TRIG, sampled in the same cycle.
REQ-008 Port O_READ_ADDR, output, ID_W: registered read address driven to the Delay_RAM I_READ_ADDR_RAMx port.
REQ-009 Port I_DELAY, input, DLY_W: Delay_RAM O_DACx_DELAY data, valid 1 cycle after O_READ_ADDR changes.
REQ-010 Port O_FIRE, output, 1: single-cycle delayed trigger pulse.
REQ-011 Port O_FIRE_ID, output, ID_W: ID of the firing trigger, valid only while O_FIRE=1, otherwise 0.
REQ-012 Port O_BUSY, output, 1: high in every state except IDLE.
REQ-013 Port O_DROP_CNT, output, 8: saturating count of rejected triggers.

Function
REQ-014 The FSM SHALL have five states: IDLE, LOOKUP, CAPTURE, COUNT, FIRE.
REQ-015 In IDLE with I_ENABLE=1 and I_TRIG=1 (cycle T), the block SHALL latch I_TX_ID into O_READ_ADDR and an internal ID register, then go to LOOKUP.
REQ-016 LOOKUP SHALL last one cycle to cover the 1-cycle RAM read latency, then go to CAPTURE.
REQ-017 In CAPTURE the block SHALL load I_DELAY into a DLY_W down-counter; it SHALL go to FIRE if I_DELAY=0, otherwise to COUNT.
REQ-018 COUNT SHALL decrement the counter by 1 each cycle and go to FIRE on the cycle the counter reaches 1 (no wrap, no underflow).
REQ-019 FIRE SHALL assert O_FIRE=1 with O_FIRE_ID equal to the latched ID for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed: O_FIRE is high in cycle T+3+D, where D is the delay value read (D=0 gives T+3; D=2^DLY_W-1 is supported).
REQ-021 Only one trigger SHALL be outstanding at a time.
REQ-022 I_TRIG=1 with I_ENABLE=1 in any non-IDLE state, including FIRE, SHALL be dropped and SHALL increment O_DROP_CNT, which saturates at 255 with no wrap.
REQ-023 I_TRIG with I_ENABLE=0 SHALL be ignored and SHALL NOT be counted.
REQ-024 I_ENABLE falling in LOOKUP, CAPTURE or COUNT SHALL abort to IDLE on the next edge with no O_FIRE.
REQ-025 I_ENABLE falling in the FIRE cycle SHALL still complete that fire pulse.
REQ-026 O_READ_ADDR SHALL hold its last value outside of accepts; I_DELAY SHALL be sampled only in CAPTURE.

Reset
REQ-027 I_Rst_n=0 at a rising edge SHALL force state IDLE, O_READ_ADDR=0, O_FIRE=0, O_FIRE_ID=0, O_BUSY=0, O_DROP_CNT=0, and clear the internal counter and ID, from any state including mid-COUNT.
REQ-028 A trigger in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-029 A shared package trig_delay_pkg SHALL hold ID_W/DLY_W defaults, the read latency constant RD_LAT=1, and the state enumeration.
REQ-030 The block SHALL be single-level RTL with no sub-module; it is instantiated once per DAC port (4 instances) between the trigger source and Delay_RAM.

Verification
REQ-031 RAM model with latency 1 holding ID3->10: I_TRIG at T with ID 3 -> O_FIRE at T+13 with O_FIRE_ID=3; O_BUSY high T+1..T+13.
REQ-032 ID5->0: I_TRIG at T -> O_FIRE at T+3 with O_FIRE_ID=5; ID5->65535: O_FIRE at T+65538.
REQ-033 Triggers at T (ID 3, delay 10) and T+4 -> single fire at T+13; O_DROP_CNT=1; a trigger at T+13 (FIRE cycle) -> O_DROP_CNT=2, no extra fire.
REQ-034 300 triggers while BUSY (delay 65535) -> O_DROP_CNT stays 255.
REQ-035 I_Rst_n low for 1 cycle at T+6 during COUNT (delay 10) -> all outputs 0 at T+7, no fire ever; new trigger after release fires with correct latency.
REQ-036 I_ENABLE low at T+5 during COUNT -> no fire, IDLE at T+6; I_TRIG with I_ENABLE=0 -> no fire, O_DROP_CNT unchanged.

Source files
------------

// File: rtl/trig_delay_pkg.sv
// Shared definitions for the per-DAC trigger delay generator: default widths,
// Delay_RAM read latency and the controller state encoding.
package trig_delay_pkg;

    localparam int ID_W_DEF  = 8;
    localparam int DLY_W_DEF = 16;
    localparam int RD_LAT    = 1;
    localparam int DROP_W    = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CAPTURE,
        ST_COUNT,
        ST_FIRE
    } state_e;

endpackage

// File: rtl/trig_delay_gen.sv
// Trigger delay generator: looks up a per-ID delay in Delay_RAM and emits a
// single-cycle fire pulse a fixed 3+D cycles after an accepted trigger.
module trig_delay_gen
    import trig_delay_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic              I_DELY_CLK,
    input  logic              I_Rst_n,
    input  logic              I_ENABLE,
    input  logic              I_TRIG,
    input  logic [ID_W-1:0]   I_TX_ID,
    output logic [ID_W-1:0]   O_READ_ADDR,
    input  logic [DLY_W-1:0]  I_DELAY,
    output logic              O_FIRE,
    output logic [ID_W-1:0]   O_FIRE_ID,
    output logic              O_BUSY,
    output logic [DROP_W-1:0] O_DROP_CNT
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              trig_en;

    assign trig_en = I_TRIG & I_ENABLE;

    always_ff @(posedge I_DELY_CLK) begin
        if (!I_Rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Any enabled trigger seen while a trigger is outstanding is dropped and counted.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;

        if (trig_en && (state_q != ST_IDLE) && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_en) begin
                    addr_d  = I_TX_ID;
                    id_d    = I_TX_ID;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = I_ENABLE ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
                if (!I_ENABLE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = I_DELAY;
                    state_d = (I_DELAY == '0) ? ST_FIRE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!I_ENABLE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) begin
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign O_READ_ADDR = addr_q;
    assign O_FIRE      = (state_q == ST_FIRE);
    assign O_FIRE_ID   = O_FIRE ? id_q : '0;
    assign O_BUSY      = (state_q != ST_IDLE);
    assign O_DROP_CNT  = drop_q;

endmodule

// File: tb/tb_trig_delay_gen.sv
// Self-checking bench for trig_delay_gen: directed latency/drop/abort/reset
// scenarios plus randomized traffic against a deadline-based reference model.
module tb_trig_delay_gen;

    localparam int ID_W  = 8;
    localparam int DLY_W = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic              en;
    logic              trig;
    logic [ID_W-1:0]   txId;
    logic [DLY_W-1:0]  delay;
    logic [ID_W-1:0]   readAddr;
    logic              fire;
    logic [ID_W-1:0]   fireId;
    logic              busy;
    logic [7:0]        dropCnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit checkEn = 0;

    int unsigned ram [256];
    int lastAddr = 0;

    // Reference model: an accepted trigger simply has a deadline cycle.
    bit mBusy   = 0;
    int mFireAt = 0;
    int mId     = 0;
    int mAddr   = 0;
    int mDrop   = 0;

    always #5 clk = ~clk;

    trig_delay_gen #(.ID_W(ID_W), .DLY_W(DLY_W)) dut (
        .I_DELY_CLK (clk),
        .I_Rst_n    (rstN),
        .I_ENABLE   (en),
        .I_TRIG     (trig),
        .I_TX_ID    (txId),
        .O_READ_ADDR(readAddr),
        .I_DELAY    (delay),
        .O_FIRE     (fire),
        .O_FIRE_ID  (fireId),
        .O_BUSY     (busy),
        .O_DROP_CNT (dropCnt)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge: checks this cycle, drives it, advances.
    task automatic applyStimulus(input bit r, input bit e, input bit t, input int id);
        bit expFire;
        if (checkEn) begin
            expFire = mBusy && (cyc == mFireAt);
            checkOutput("fire",     int'(fire),     int'(expFire));
            checkOutput("fireId",   int'(fireId),   expFire ? mId : 0);
            checkOutput("busy",     int'(busy),     int'(mBusy));
            checkOutput("readAddr", int'(readAddr), mAddr);
            checkOutput("dropCnt",  int'(dropCnt),  mDrop);
        end
        delay    = DLY_W'(ram[lastAddr]);
        lastAddr = int'(readAddr);
        rstN = r;
        en   = e;
        trig = t;
        txId = ID_W'(id);

        if (!r) begin
            mBusy = 0;
            mAddr = 0;
            mId   = 0;
            mDrop = 0;
        end else if (!mBusy) begin
            if (e && t) begin
                mBusy   = 1;
                mId     = id;
                mAddr   = id;
                mFireAt = cyc + 3 + int'(ram[id]);
            end
        end else begin
            if (e && t && mDrop < 255) mDrop++;
            if (cyc == mFireAt) mBusy = 0;
            else if (!e) mBusy = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom_range(0, 15);
        ram[3] = 10;
        ram[5] = 0;
        rstN = 0; en = 0; trig = 0; txId = '0; delay = '0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 0, 0);
        checkEn = 1;
        applyStimulus(0, 1, 1, 9);
        applyStimulus(0, 0, 0, 0);

        // First cycle after reset release: accepted; ID3 fires 13 cycles later.
        for (int k = 0; k < 18; k++) applyStimulus(1, 1, k == 0, 3);

        // Zero delay fires at T+3.
        for (int k = 0; k < 6; k++) applyStimulus(1, 1, k == 0, 5);

        // Drops at T+4 and in the FIRE cycle T+13.
        for (int k = 0; k < 18; k++) applyStimulus(1, 1, (k == 0) || (k == 4) || (k == 13), (k == 4) ? 9 : 3);

        // Reset mid-COUNT, then a fresh trigger.
        for (int k = 0; k < 20; k++) applyStimulus(k != 6, 1, k == 0, 3);
        for (int k = 0; k < 16; k++) applyStimulus(1, 1, k == 0, 3);

        // Enable falls during COUNT; then disabled triggers are ignored.
        for (int k = 0; k < 16; k++) applyStimulus(1, k != 5, k == 0, 3);
        for (int k = 0; k < 6; k++) applyStimulus(1, 0, 1, 3);
        applyStimulus(1, 1, 0, 0);

        // Maximum delay with 300 dropped triggers saturating the counter.
        ram[5] = 65535;
        applyStimulus(1, 1, 0, 0);
        for (int k = 0; k < 65543; k++) applyStimulus(1, 1, (k == 0) || (k >= 1 && k <= 300), 5);
        ram[5] = 0;
        applyStimulus(1, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 2) == 0, int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
